// File: rtl/mux_nx1_scan_reg_if.sv
// Bus bundle for mux_nx1_scan_reg: channel inputs and controls in, registered capture results out.
// The err output exists only when MUXN_SEL_ERR_EN is defined.
interface mux_nx1_scan_reg_if #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SELW  = 3
);
    logic [N*WIDTH-1:0] din;
    logic [SELW-1:0]    sel;
    logic               mode;
    logic               en;
    logic [WIDTH-1:0]   y;
    logic               y_valid;
    logic [SELW-1:0]    ch;
    logic               wrap;
    logic               state;
`ifdef MUXN_SEL_ERR_EN
    logic               err;
`endif

    // Handshake: en is a one-cycle capture strobe with no backpressure; y_valid
    // pulses for exactly one cycle on the edge after an accepted capture and
    // y/ch are stable until the next pulse.
`ifdef MUXN_SEL_ERR_EN
    modport master (
        output din, sel, mode, en,
        input  y, y_valid, ch, wrap, state, err
    );
    modport slave (
        input  din, sel, mode, en,
        output y, y_valid, ch, wrap, state, err
    );
`else
    modport master (
        output din, sel, mode, en,
        input  y, y_valid, ch, wrap, state
    );
    modport slave (
        input  din, sel, mode, en,
        output y, y_valid, ch, wrap, state
    );
`endif
endinterface

// File: rtl/mux_nx1_scan_reg.sv
// N-to-1 registered channel mux with manual select and auto-scan sequencing.
// Optional feature macro: MUXN_SEL_ERR_EN (adds err flag for out-of-range manual select).
module mux_nx1_scan_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 8,
    parameter int SELW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mux_nx1_scan_reg_if.slave      bus
);
    localparam logic [0:0]      ST_MAN  = 1'b0;
    localparam logic [0:0]      ST_SCAN = 1'b1;
    localparam logic [SELW-1:0] LAST    = SELW'(N - 1);

    logic [0:0]       state;
    logic [SELW-1:0]  cnt;
    logic [SELW-1:0]  scan_idx;
    logic [WIDTH-1:0] scan_data;
    logic [WIDTH-1:0] man_data;
    logic             sel_ok;
    logic [WIDTH-1:0] y_q;
    logic [SELW-1:0]  ch_q;
    logic             y_valid_q;
    logic             wrap_q;
`ifdef MUXN_SEL_ERR_EN
    logic             err_q;
`endif

    // Entering SCAN always starts from channel 0, even if cnt were stale.
    assign scan_idx = (state == ST_SCAN) ? cnt : '0;

    // A select matching no channel index leaves sel_ok low; with N a power of
    // two every encoding matches, so no out-of-range case exists.
    always_comb begin
        scan_data = '0;
        man_data  = '0;
        sel_ok    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (scan_idx == SELW'(k)) scan_data = bus.din[k*WIDTH +: WIDTH];
            if (bus.sel == SELW'(k)) begin
                man_data = bus.din[k*WIDTH +: WIDTH];
                sel_ok   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_MAN;
            cnt       <= '0;
            y_q       <= '0;
            ch_q      <= '0;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
`ifdef MUXN_SEL_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
`ifdef MUXN_SEL_ERR_EN
            err_q     <= 1'b0;
`endif
            state <= bus.mode ? ST_SCAN : ST_MAN;
            // Leaving SCAN (or idling in MAN) parks the counter at channel 0.
            if (!bus.mode) cnt <= '0;

            if (bus.en) begin
                if (bus.mode) begin
                    y_q       <= scan_data;
                    ch_q      <= scan_idx;
                    y_valid_q <= 1'b1;
                    wrap_q    <= (scan_idx == LAST);
                    cnt       <= (scan_idx == LAST) ? '0 : scan_idx + SELW'(1);
                end else if (sel_ok) begin
                    y_q       <= man_data;
                    ch_q      <= bus.sel;
                    y_valid_q <= 1'b1;
                end
`ifdef MUXN_SEL_ERR_EN
                else begin
                    y_q   <= '0;
                    ch_q  <= bus.sel;
                    err_q <= 1'b1;
                end
`endif
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.ch      = ch_q;
    assign bus.y_valid = y_valid_q;
    assign bus.wrap    = wrap_q;
    assign bus.state   = state;
`ifdef MUXN_SEL_ERR_EN
    assign bus.err     = err_q;
`endif
endmodule

// File: tb/tb_mux_nx1_scan_reg.sv
// Directed bench for mux_nx1_scan_reg: an 8-channel and a 6-channel instance,
// scoreboard queues checked by per-instance monitors on y_valid.
module tb_mux_nx1_scan_reg;
    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    logic [11:0] exp8_q[$];
    logic [11:0] exp6_q[$];

    mux_nx1_scan_reg_if #(.WIDTH(8), .N(8), .SELW(3)) bus8 ();
    mux_nx1_scan_reg_if #(.WIDTH(8), .N(6), .SELW(3)) bus6 ();

    mux_nx1_scan_reg #(.WIDTH(8), .N(8), .SELW(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    mux_nx1_scan_reg #(.WIDTH(8), .N(6), .SELW(3)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // driver tasks: expected {wrap, ch, y} pushed on a capture, hold checked otherwise
    task automatic step8(input logic m, input logic e, input logic [2:0] s, input logic ev,
                         input logic [7:0] ey, input logic [2:0] ech, input logic ew);
        bus8.mode = m;
        bus8.en   = e;
        bus8.sel  = s;
        if (ev) exp8_q.push_back({ew, ech, ey});
        @(posedge clk);
        #1;
        if (!ev) begin
            check("dut8 hold y_valid", 32'(bus8.y_valid), 32'd0);
            check("dut8 hold wrap", 32'(bus8.wrap), 32'd0);
            check("dut8 hold y", 32'(bus8.y), 32'(ey));
            check("dut8 hold ch", 32'(bus8.ch), 32'(ech));
        end
    endtask

    task automatic step6(input logic m, input logic e, input logic [2:0] s, input logic ev,
                         input logic [7:0] ey, input logic [2:0] ech, input logic ew);
        bus6.mode = m;
        bus6.en   = e;
        bus6.sel  = s;
        if (ev) exp6_q.push_back({ew, ech, ey});
        @(posedge clk);
        #1;
        if (!ev) begin
            check("dut6 hold y_valid", 32'(bus6.y_valid), 32'd0);
            check("dut6 hold wrap", 32'(bus6.wrap), 32'd0);
            check("dut6 y", 32'(bus6.y), 32'(ey));
            check("dut6 ch", 32'(bus6.ch), 32'(ech));
        end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus8.y_valid === 1'b1) begin
            if (exp8_q.size() == 0) check("dut8 unexpected y_valid", 32'd1, 32'd0);
            else check("dut8 capture {wrap,ch,y}", 32'({bus8.wrap, bus8.ch, bus8.y}), 32'(exp8_q.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus6.y_valid === 1'b1) begin
            if (exp6_q.size() == 0) check("dut6 unexpected y_valid", 32'd1, 32'd0);
            else check("dut6 capture {wrap,ch,y}", 32'({bus6.wrap, bus6.ch, bus6.y}), 32'(exp6_q.pop_front()));
        end
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        for (int k = 0; k < 8; k++) bus8.din[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 6; k++) bus6.din[k*8 +: 8] = 8'(8'h20 + k);
        bus8.sel = '0; bus8.mode = 1'b0; bus8.en = 1'b0;
        bus6.sel = '0; bus6.mode = 1'b0; bus6.en = 1'b0;

        #2;
        check("reset y", 32'(bus8.y), 32'd0);
        check("reset ch", 32'(bus8.ch), 32'd0);
        check("reset y_valid", 32'(bus8.y_valid), 32'd0);
        check("reset wrap", 32'(bus8.wrap), 32'd0);
        check("reset state", 32'(bus8.state), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // manual capture of channel 5, then hold
        step8(1'b0, 1'b1, 3'd5, 1'b1, 8'h15, 3'd5, 1'b0);
        step8(1'b0, 1'b0, 3'd5, 1'b0, 8'h15, 3'd5, 1'b0);

        // auto-scan 9 captures: 0..7 then 0, wrap on channel 7
        for (int i = 0; i < 9; i++)
            step8(1'b1, 1'b1, 3'd0, 1'b1, 8'(8'h10 + (i % 8)), 3'(i % 8), (i == 7));
        check("scan state", 32'(bus8.state), 32'd1);

        // back to manual without capture clears counter; scan with en gaps
        step8(1'b0, 1'b0, 3'd0, 1'b0, 8'h10, 3'd0, 1'b0);
        step8(1'b1, 1'b1, 3'd0, 1'b1, 8'h10, 3'd0, 1'b0);
        step8(1'b1, 1'b0, 3'd0, 1'b0, 8'h10, 3'd0, 1'b0);
        step8(1'b1, 1'b1, 3'd0, 1'b1, 8'h11, 3'd1, 1'b0);

        // scan on to channel 3, one manual cycle, resume at channel 0
        step8(1'b1, 1'b1, 3'd0, 1'b1, 8'h12, 3'd2, 1'b0);
        step8(1'b1, 1'b1, 3'd0, 1'b1, 8'h13, 3'd3, 1'b0);
        step8(1'b0, 1'b0, 3'd0, 1'b0, 8'h13, 3'd3, 1'b0);
        step8(1'b1, 1'b1, 3'd0, 1'b1, 8'h10, 3'd0, 1'b0);
        step8(1'b1, 1'b1, 3'd0, 1'b1, 8'h11, 3'd1, 1'b0);

        // asynchronous reset mid-scan, away from any clock edge
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async reset y", 32'(bus8.y), 32'd0);
        check("async reset ch", 32'(bus8.ch), 32'd0);
        check("async reset y_valid", 32'(bus8.y_valid), 32'd0);
        check("async reset wrap", 32'(bus8.wrap), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step8(1'b1, 1'b1, 3'd0, 1'b1, 8'h10, 3'd0, 1'b0);
        step8(1'b1, 1'b0, 3'd0, 1'b0, 8'h10, 3'd0, 1'b0);
        step8(1'b0, 1'b0, 3'd0, 1'b0, 8'h10, 3'd0, 1'b0);

        // N=6 instance: manual in range, then out of range sel=7
        step6(1'b0, 1'b1, 3'd2, 1'b1, 8'h22, 3'd2, 1'b0);
`ifdef MUXN_SEL_ERR_EN
        step6(1'b0, 1'b1, 3'd7, 1'b0, 8'h00, 3'd7, 1'b0);
        check("dut6 err set", 32'(bus6.err), 32'd1);
        step6(1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 3'd7, 1'b0);
        check("dut6 err pulse", 32'(bus6.err), 32'd0);
`else
        step6(1'b0, 1'b1, 3'd7, 1'b0, 8'h22, 3'd2, 1'b0);
        step6(1'b0, 1'b0, 3'd7, 1'b0, 8'h22, 3'd2, 1'b0);
`endif
        // N=6 scan wraps after channel 5
        for (int i = 0; i < 7; i++)
            step6(1'b1, 1'b1, 3'd0, 1'b1, 8'(8'h20 + (i % 6)), 3'(i % 6), (i == 5));
        step6(1'b0, 1'b0, 3'd0, 1'b0, 8'h20, 3'd0, 1'b0);

        @(negedge clk);
        check("dut8 queue drained", 32'(exp8_q.size()), 32'd0);
        check("dut6 queue drained", 32'(exp6_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mux_nx1_scan_reg.md
MUX_NX1_SCAN_REG -- requirements
Module: mux_nx1_scan_reg

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  WIDTH, 8, data bits per channel
  N, 8, channel count (2..256)
  SELW, 3, select width (equal to ceil(log2(N)), minimum 1)
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk, in, 1, single clock, rising edge
  rst_n, in, 1, asynchronous active-low reset
  din, in, N*WIDTH, flattened channels; channel k = din[k*WIDTH +: WIDTH]
  sel, in, SELW, manual channel select
  mode, in, 1, 0 = manual, 1 = auto-scan
  en, in, 1, advance/capture strobe
  y, out, WIDTH, registered selected data
  y_valid, out, 1, y updated this cycle (one-cycle pulse)
  ch, out, SELW, channel index captured into y
  wrap, out, 1, auto-scan wrapped from N-1 to 0 (one-cycle pulse)
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 Capture latency SHALL be 1 cycle: y reflects din sampled on the edge where en=1.
REQ-005 With en=0, y, ch and scan counter SHALL hold; y_valid and wrap SHALL be 0.
REQ-006 Manual mode (mode=0, en=1) SHALL capture: y <= channel sel; ch <= sel; y_valid <= 1.
REQ-007 Auto mode SHALL use the two-state FSM: MAN (mode=0) and SCAN (mode=1).
REQ-008 On the MAN->SCAN transition, the scan counter SHALL be 0.
REQ-009 In SCAN with en=1, the block SHALL update: y <= channel cnt; ch <= cnt; y_valid <= 1; cnt <= (cnt==N-1) ? 0 : cnt+1.
REQ-010 wrap SHALL pulse on the same edge that y is loaded from channel N-1 in SCAN.
REQ-011 Mode SHALL be sampled on the same edge as en; a capture on the switching edge SHALL use the new mode.
  - Example: mode 0->1 with en=1 captures channel 0.
REQ-012 SCAN->MAN SHALL clear cnt to 0 and SHALL NOT pulse wrap.
REQ-013 A manual sel >= N SHALL be out-of-range. The behaviour SHALL be per REQ-019/020.
REQ-014 When N is a power of 2, no out-of-range condition SHALL exist.
REQ-015 Outputs SHALL be registered only; there SHALL be no combinational path from din/sel to y.

Reset
REQ-016 While rst_n=0, the block SHALL hold: y=0; ch=0; y_valid=0; wrap=0; cnt=0; FSM=MAN (err=0 if present).
REQ-017 Reset assertion mid-scan SHALL take effect immediately (asynchronous) and SHALL abort the sequence.
  - After release, the first SCAN capture SHALL be channel 0.
REQ-018 Reset deassertion SHALL be synchronised externally; the block SHALL NOT resynchronise rst_n.

Configuration
REQ-019 With macro MUXN_SEL_ERR_EN defined:
  - an output err (1 bit) SHALL be present;
  - a manual out-of-range capture SHALL set err=1 for one cycle, load y=0, set ch=sel, and keep y_valid=0.
REQ-020 With MUXN_SEL_ERR_EN undefined:
  - err SHALL be absent;
  - an out-of-range manual capture SHALL be ignored: y, ch hold; y_valid=0.

Verification
REQ-021 Reset: assert rst_n=0 mid-stream -> y=0, ch=0, y_valid=0, wrap=0 within the same cycle, without a clock edge.
REQ-022 Manual: WIDTH=8, N=8, din channel k = 8'h10+k, mode=0, sel=5, en=1 for one cycle -> next cycle y=8'h15, ch=5, y_valid=1, then y_valid=0 with y held.
REQ-023 Scan wrap: N=8, mode=1, en=1 for 9 cycles -> y sequence 8'h10..8'h17 then 8'h10; wrap=1 only on the 8'h17 capture.
REQ-024 Scan with gaps: mode=1, en pattern 1,0,1 -> captures channels 0 then 1; y and ch held during the en=0 cycle.
REQ-025 Mode switch: scan to channel 3, set mode=0 for one cycle, then mode=1 with en=1 -> capture channel 0, no wrap pulse.
REQ-026 Out-of-range: N=6, SELW=3, sel=7, en=1:
  - with MUXN_SEL_ERR_EN: err=1, y=0, y_valid=0;
  - without it: y and ch unchanged, y_valid=0.
